// File: rtl/clk_sel_ctrl_if.sv
// Request handshake between a frequency-change requester and clk_sel_ctrl.
// The master drives valid and sel. The slave returns ready.
interface clk_sel_ctrl_if;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;

  modport master (output req_valid, output req_sel, input req_ready);
  modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/clk_sel_ctrl.sv
// Request sequencer feeding the glitch-free 800/500/1000 MHz clock switch.
// It holds clk_sel for a settle window after each change, and DC scan forces the OCC (1000 MHz) selection.
module clk_sel_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [1:0]  RESET_SEL     = 2'b00
) (
  input  logic                 clk_800,
  input  logic                 rst_clk_n,
  clk_sel_ctrl_if.slave        req,
  input  logic                 dc_scan_mode,
  output logic [1:0]           clk_sel,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          sw_count
);

  // state  | meaning
  // IDLE   | clk_sel stable, ready for a request
  // SETTLE | clk_sel changed, waiting for the switch synchronisers to hand over
  // DONE   | single-cycle completion pulse
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 8 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("clk_sel_ctrl: SETTLE_CYCLES must be within 8..255");
    end
    if (RESET_SEL == 2'b11) begin : g_bad_reset_sel
      $error("clk_sel_ctrl: RESET_SEL 2'b11 is not a legal selection");
    end
  endgenerate

  state_e        state_q;
  logic [1:0]    clk_sel_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [15:0]   sw_count_q;

  logic [1:0]    sel_d;
  logic          accept_d;

  // 2'b11 is an alias for the 1000 MHz selection
  assign sel_d         = (req.req_sel == 2'b11) ? 2'b10 : req.req_sel;
  assign req.req_ready = (state_q == ST_IDLE) & ~dc_scan_mode;
  assign accept_d      = req.req_valid & req.req_ready;

  always_ff @(posedge clk_800 or negedge rst_clk_n) begin
    if (!rst_clk_n) begin
      state_q    <= ST_IDLE;
      clk_sel_q  <= RESET_SEL;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sw_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (dc_scan_mode) begin
        // An in-flight switch is abandoned without a done pulse or count.
        state_q   <= ST_IDLE;
        clk_sel_q <= 2'b10;
        cnt_q     <= '0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept_d) begin
              busy_q <= 1'b1;
              if (sel_d == clk_sel_q) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                clk_sel_q <= sel_d;
                cnt_q     <= SETTLE_LOAD;
                state_q   <= ST_SETTLE;
              end
            end
          end
          ST_SETTLE: begin
            if (cnt_q == '0) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              sw_count_q <= sw_count_q + 16'd1;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clk_sel  = clk_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sw_count = sw_count_q;

endmodule
